// File: rtl/hpt_multi.sv
// Multi-channel high precision timer: CHANNELS independent reloading down-counters
// behind one zero-wait-state bus slave port.

module hpt_chan #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_div_we,
   input  logic             i_ctrl_we,
   input  logic             i_stat_rd,
   input  logic [WIDTH-1:0] i_data,
   input  logic [2:0]       i_ctrl,
   output logic [WIDTH-1:0] o_div,
   output logic [WIDTH-1:0] o_cnt,
   output logic [2:0]       o_ctrl,
   output logic             o_exp
);
   logic [WIDTH-1:0] r_div, r_cnt;
   logic             r_load, r_run, r_os, r_ien, r_uf, r_exp;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div  <= '1;
         r_cnt  <= '1;
         r_load <= 1'b1;
         r_run  <= 1'b1;
         r_os   <= 1'b0;
         r_ien  <= 1'b0;
         r_uf   <= 1'b0;
         r_exp  <= 1'b0;
      end else begin
         r_uf   <= 1'b0;
         r_load <= i_div_we;
         if (i_div_we) r_div <= i_data;
         if (r_load) r_cnt <= r_div;
         else if (r_run) begin
            if (r_cnt == WIDTH'(1)) begin
               // A divisor write landing on the terminal count suppresses the underflow.
               if (i_div_we) r_cnt <= i_data;
               else begin
                  r_cnt <= r_div;
                  r_uf  <= 1'b1;
                  if (r_os) r_run <= 1'b0;
               end
            end else begin
               r_cnt <= r_cnt - WIDTH'(1);
            end
         end
         // Placed after the auto-stop so a same-edge CTRL write decides run.
         if (i_ctrl_we) {r_os, r_run, r_ien} <= i_ctrl;
         if (r_uf) r_exp <= 1'b1;
         else if (i_stat_rd) r_exp <= 1'b0;
      end
   end

   assign o_div  = r_div;
   assign o_cnt  = r_cnt;
   assign o_ctrl = {r_os, r_run, r_ien};
   assign o_exp  = r_exp;
endmodule

module hpt_multi #(
   parameter  int CHANNELS = 4,
   parameter  int WIDTH    = 32,
   localparam int AW       = $clog2(CHANNELS) + 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_stb,
   input  logic                i_we,
   input  logic [AW-1:0]       i_addr,
   input  logic [31:0]         i_data_in,
   output logic [31:0]         o_data_out,
   output logic                o_ack,
   output logic                o_irq,
   output logic [CHANNELS-1:0] o_irq_vec
);
   logic [3:0]                       w_ch;
   logic [1:0]                       w_reg;
   logic [CHANNELS-1:0]              w_sel, w_exp;
   logic [CHANNELS-1:0][WIDTH-1:0]   w_div, w_cnt;
   logic [CHANNELS-1:0][2:0]         w_ctrl;
   logic                             w_unused;

   if (AW > 2) begin : g_chidx
      assign w_ch = 4'(i_addr[AW-1:2]);
   end else begin : g_chidx0
      assign w_ch = 4'd0;
   end
   assign w_reg    = i_addr[1:0];
   assign w_unused = ^(i_data_in >> WIDTH);

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign w_sel[c] = i_stb & (w_ch == 4'(c));
      hpt_chan #(.WIDTH(WIDTH)) u_chan (
         .clk       (clk),
         .rst       (rst),
         .i_div_we  (w_sel[c] & i_we & (w_reg == 2'd0)),
         .i_ctrl_we (w_sel[c] & i_we & (w_reg == 2'd2)),
         .i_stat_rd (w_sel[c] & ~i_we & (w_reg == 2'd3)),
         .i_data    (i_data_in[WIDTH-1:0]),
         .i_ctrl    (i_data_in[2:0]),
         .o_div     (w_div[c]),
         .o_cnt     (w_cnt[c]),
         .o_ctrl    (w_ctrl[c]),
         .o_exp     (w_exp[c])
      );
      assign o_irq_vec[c] = w_exp[c] & w_ctrl[c][0];
   end

   // Indices past the last channel fall through to zero.
   always_comb begin
      o_data_out = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (w_ch == 4'(c)) begin
            case (w_reg)
               2'd0:    o_data_out = 32'(w_div[c]);
               2'd1:    o_data_out = 32'(w_cnt[c]);
               2'd2:    o_data_out = 32'(w_ctrl[c]);
               default: o_data_out = {30'd0, w_ctrl[c][1], w_exp[c]};
            endcase
         end
      end
   end

   assign o_ack = i_stb;
   assign o_irq = |o_irq_vec;
endmodule

// File: tb/tb_hpt_multi.sv
// Randomised and directed bench for hpt_multi against a behavioural timer model.

module tb_hpt_multi;
   localparam int CH = 3;
   localparam int W  = 8;
   localparam int AW = $clog2(CH) + 2;
   localparam int M  = 1 << W;

   logic          clk = 1'b0;
   logic          rst, stb, we;
   logic [AW-1:0] addr;
   logic [31:0]   din, dout;
   logic          ack, irq;
   logic [CH-1:0] irqv, s_irqv;

   always #5 clk = ~clk;

   hpt_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .i_stb(stb), .i_we(we), .i_addr(addr), .i_data_in(din),
      .o_data_out(dout), .o_ack(ack), .o_irq(irq), .o_irq_vec(irqv)
   );

   int n_chk = 0, n_pass = 0, cyc = 0;
   int m_div[CH], m_cnt[CH];
   bit m_pend[CH], m_run[CH], m_os[CH], m_ien[CH], m_exp[CH], m_uf[CH];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic m_reset();
      for (int c = 0; c < CH; c++) begin
         m_div[c] = M - 1; m_cnt[c] = M - 1; m_pend[c] = 1; m_run[c] = 1;
         m_os[c] = 0; m_ien[c] = 0; m_exp[c] = 0; m_uf[c] = 0;
      end
   endtask

   function automatic logic [CH-1:0] m_irqv();
      logic [CH-1:0] v;
      for (int c = 0; c < CH; c++) v[c] = m_exp[c] & m_ien[c];
      return v;
   endfunction

   function automatic logic [31:0] m_read(input int a);
      int c = a >> 2;
      if (c >= CH) return 32'd0;
      case (a & 3)
         0:       return m_div[c];
         1:       return m_cnt[c];
         2:       return {m_os[c], m_run[c], m_ien[c]};
         default: return {m_run[c], m_exp[c]};
      endcase
   endfunction

   // One clock edge of the timer rules, all channels, given this cycle's bus op.
   task automatic m_step(input bit s, input bit w, input int a, input logic [31:0] d);
      for (int c = 0; c < CH; c++) begin
         bit hit, divw, ctrlw, statr, nuf;
         int dv;
         hit   = s && ((a >> 2) == c);
         divw  = hit && w && ((a & 3) == 0);
         ctrlw = hit && w && ((a & 3) == 2);
         statr = hit && !w && ((a & 3) == 3);
         dv    = int'(d % M);
         nuf   = 0;
         if (m_pend[c]) m_cnt[c] = m_div[c];
         else if (m_run[c]) begin
            if (m_cnt[c] == 1) begin
               if (divw) m_cnt[c] = dv;
               else begin
                  m_cnt[c] = m_div[c]; nuf = 1;
                  if (m_os[c]) m_run[c] = 0;
               end
            end else m_cnt[c] = (m_cnt[c] + M - 1) % M;
         end
         if (m_uf[c]) m_exp[c] = 1;
         else if (statr) m_exp[c] = 0;
         m_uf[c]   = nuf;
         m_pend[c] = divw;
         if (divw) m_div[c] = dv;
         if (ctrlw) begin m_ien[c] = d[0]; m_run[c] = d[1]; m_os[c] = d[2]; end
      end
   endtask

   task automatic op(input bit s, input bit w, input int a, input logic [31:0] d,
                     output logic [31:0] rd);
      logic [CH-1:0] ev;
      stb = s; we = w; addr = AW'(a); din = d; cyc++;
      #4;
      ev = m_irqv();
      s_irqv = irqv;
      chk("irq_vec", 32'(irqv), 32'(ev));
      chk("irq", 32'(irq), 32'(|ev));
      chk("ack", 32'(ack), 32'(s));
      if (s && !w) chk($sformatf("read_a%0d", a), dout, m_read(a));
      rd = dout;
      @(posedge clk);
      m_step(s, w, a, d);
      #1;
   endtask

   task automatic idle(input int n);
      logic [31:0] x;
      for (int i = 0; i < n; i++) op(0, 0, 0, 0, x);
   endtask
   task automatic wr(input int a, input logic [31:0] d);
      logic [31:0] x;
      op(1, 1, a, d, x);
   endtask
   task automatic rd(input int a, output logic [31:0] v);
      op(1, 0, a, 0, v);
   endtask

   task automatic do_reset();
      rst = 1; stb = 0; we = 0; cyc++;
      @(posedge clk);
      m_reset();
      #1;
      rst = 0;
   endtask

   initial begin
      logic [31:0] v;
      int r1, r2;
      stb = 0; we = 0; addr = '0; din = '0; rst = 1;
      do_reset();

      // reset defaults
      idle(1);
      rd(1, v); chk("rst_cnt_a", v, 255);
      idle(4);
      rd(1, v); chk("rst_cnt_b", v, 250);
      for (int c = 0; c < CH; c++) begin rd(c * 4 + 3, v); chk("rst_stat", v, 2); end
      rd(12, v); chk("bad_chan", v, 0);

      // periodic, channel 1
      wr(4, 10); wr(6, 3); idle(2);
      v = 0;
      for (int i = 0; i < 15 && v != 1; i++) rd(5, v);
      chk("cnt_reach1", v, 1);
      idle(1); chk("irq1_pre", 32'(s_irqv[1]), 0);
      idle(1); chk("irq1_rise", 32'(s_irqv[1]), 1); r1 = cyc;
      rd(7, v); chk("stat_set", v, 3);
      rd(7, v); chk("stat_clr", v, 2);
      r2 = 0;
      for (int i = 0; i < 20; i++) begin idle(1); if (s_irqv[1]) begin r2 = cyc; break; end end
      chk("period10", r2 - r1, 10);

      // one-shot, channel 2
      wr(8, 5); wr(10, 7); idle(12);
      rd(11, v); chk("os_stat", v, 1);
      rd(9, v);  chk("os_cnt", v, 5);
      wr(10, 7);
      idle(6); chk("os2_pre", 32'(s_irqv[2]), 0);
      idle(1); chk("os2_fire", 32'(s_irqv[2]), 1);
      rd(11, v); chk("os2_stat", v, 1);
      // CTRL run=1 written on the auto-stop edge
      wr(10, 7); idle(4); wr(10, 7);
      rd(11, v); chk("os_coll_run", v, 2);
      rd(11, v); chk("os_coll_exp", v, 3);
      rd(9, v);  chk("os_coll_cnt", v, 3);

      // divisor 1, channel 0: set wins over clear every cycle
      wr(0, 1); wr(2, 3); idle(2);
      for (int i = 0; i < 4; i++) begin rd(3, v); chk("div1_stat", v, 3); end

      // divisor 0 gives 2^W period
      wr(0, 0); wr(2, 3);
      rd(3, v);
      r1 = 0; r2 = 0;
      for (int i = 0; i < 300; i++) begin idle(1); if (s_irqv[0]) begin r1 = cyc; break; end end
      rd(3, v);
      for (int i = 0; i < 300; i++) begin idle(1); if (s_irqv[0]) begin r2 = cyc; break; end end
      chk("period_div0", r2 - r1, 256);

      // DIV write on the terminal count of channel 1
      v = 0;
      for (int i = 0; i < 12; i++) begin rd(5, v); if (v >= 3) break; end
      r1 = int'(v);
      rd(7, v);
      idle(r1 - 3);
      wr(4, 7);
      idle(1);
      rd(5, v); chk("coll_cnt", v, 7);
      rd(7, v); chk("coll_nouf", v, 2);

      // stop and resume, channel 1
      wr(6, 1); idle(2); rd(5, v); idle(4); rd(5, v);
      wr(6, 3); idle(3); rd(5, v);

      // random traffic
      for (int i = 0; i < 800; i++) begin
         int a;
         logic [31:0] d;
         bit s, w;
         s = 1'($urandom_range(0, 1));
         w = 1'($urandom_range(0, 1));
         a = $urandom_range(0, 15);
         d = ((a & 3) == 0) ? 32'($urandom_range(0, 12)) : $urandom;
         op(s, w, a, d, v);
      end

      // mid-count reset
      do_reset();
      for (int c = 0; c < CH; c++) begin rd(c * 4 + 3, v); chk("rst2_stat", v, 2); end
      rd(0, v); chk("rst2_div", v, 255);
      rd(2, v); chk("rst2_ctrl", v, 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
